// File: rtl/ram_param.sv
// ram_param: parametrised single-port synchronous RAM.
//
// Configurable width, depth and read latency (1 or 2). Same-address
// read+write in one cycle returns the old word (RW_MODE=0) or data_in
// (RW_MODE=1). With CLEAR_ON_RESET=1 every word is zeroed by a sweep of
// DEPTH cycles after reset release. Commands to an address >= DEPTH are
// flagged on addr_err, aligned with where a read result would appear.
//
// Ports:
//   clk        clock, all state changes on posedge
//   reset      asynchronous active-low reset
//   write_enb  write strobe, sampled on posedge
//   read_enb   read strobe, sampled on posedge
//   address    word address for read and write
//   data_in    write data
//   data_out   registered read data, holds between results
//   data_valid one-cycle pulse with each read result
//   ready      1 = accepting commands; 0 during reset and clear sweep
//   addr_err   one-cycle pulse for any command with address >= DEPTH
module ram_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 5,
    parameter int DEPTH          = 32,
    parameter int RD_LATENCY     = 1,
    parameter int RW_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  ready,
    output logic                  addr_err
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram_param: RD_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("ram_param: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH");
    end

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    // first pipeline stage, loaded on the sampling edge
    logic                  cap_v;
    logic                  cap_e;
    logic [DATA_WIDTH-1:0] cap_d;
    // stage feeding the output registers
    logic                  last_v;
    logic                  last_e;
    logic [DATA_WIDTH-1:0] last_d;

    assign in_range = {1'b0, address} < DEPTH_EXT;

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == LAST_ADDR) begin
            state_next = RUN;
        end
    end

    // ready is the registered "in RUN" flag; it also gates command
    // acceptance, so the first edge after reset never takes a command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == RUN);
            if (state == CLEAR) begin
                clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
            end
        end
    end

    // Memory array has no reset; only the sweep or accepted writes touch it.
    always_ff @(posedge clk) begin
        if (ready) begin
            if (write_enb && in_range) begin
                mem[address] <= data_in;
            end
        end else if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end
    end

    always_comb begin
        rd_word = '0;
        if (!in_range) begin
            rd_word = '0;
        end else if (RW_MODE != 0 && write_enb) begin
            rd_word = data_in;
        end else begin
            rd_word = mem[address];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_v <= 1'b0;
            cap_e <= 1'b0;
            cap_d <= '0;
        end else begin
            cap_v <= ready && read_enb;
            cap_e <= ready && (read_enb || write_enb) && !in_range;
            if (ready && read_enb) begin
                cap_d <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                last_v <= 1'b0;
                last_e <= 1'b0;
                last_d <= '0;
            end else begin
                last_v <= cap_v;
                last_e <= cap_e;
                last_d <= cap_d;
            end
        end
    end else begin : g_lat1
        assign last_v = cap_v;
        assign last_e = cap_e;
        assign last_d = cap_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            data_valid <= last_v;
            addr_err   <= last_e;
            if (last_v) begin
                data_out <= last_d;
            end
        end
    end

endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: four ram_param configurations driven by one shared
// stimulus stream and checked every cycle against an array-based model,
// plus literal expectations for the clear sweep, latency, read-during-write,
// out-of-range and reset cases.
module tb_ram_param;

    localparam int NDUT = 4;
    localparam int P_DEPTH [NDUT] = '{32, 24, 20, 32};
    localparam int P_LAT   [NDUT] = '{1, 2, 1, 2};
    localparam int P_RW    [NDUT] = '{0, 1, 1, 0};
    localparam int P_CLR   [NDUT] = '{1, 1, 0, 1};

    logic       clk;
    logic       reset;
    logic       write_enb;
    logic       read_enb;
    logic [4:0] address;
    logic [7:0] data_in;

    logic [7:0] dout [NDUT];
    logic       vld  [NDUT];
    logic       rdy  [NDUT];
    logic       err  [NDUT];

    int total = 0;
    int bad   = 0;

    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .RD_LATENCY(1),
                .RW_MODE(0), .CLEAR_ON_RESET(1)) u_d0 (
        .clk(clk), .reset(reset), .write_enb(write_enb), .read_enb(read_enb),
        .address(address), .data_in(data_in), .data_out(dout[0]),
        .data_valid(vld[0]), .ready(rdy[0]), .addr_err(err[0]));

    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(24), .RD_LATENCY(2),
                .RW_MODE(1), .CLEAR_ON_RESET(1)) u_d1 (
        .clk(clk), .reset(reset), .write_enb(write_enb), .read_enb(read_enb),
        .address(address), .data_in(data_in), .data_out(dout[1]),
        .data_valid(vld[1]), .ready(rdy[1]), .addr_err(err[1]));

    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(20), .RD_LATENCY(1),
                .RW_MODE(1), .CLEAR_ON_RESET(0)) u_d2 (
        .clk(clk), .reset(reset), .write_enb(write_enb), .read_enb(read_enb),
        .address(address), .data_in(data_in), .data_out(dout[2]),
        .data_valid(vld[2]), .ready(rdy[2]), .addr_err(err[2]));

    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .RD_LATENCY(2),
                .RW_MODE(0), .CLEAR_ON_RESET(1)) u_d3 (
        .clk(clk), .reset(reset), .write_enb(write_enb), .read_enb(read_enb),
        .address(address), .data_in(data_in), .data_out(dout[3]),
        .data_valid(vld[3]), .ready(rdy[3]), .addr_err(err[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic       e;
        logic [7:0] d;
        logic       kn;
    } res_t;

    logic [7:0] mem_m   [NDUT][32];
    bit         kn_m    [NDUT][32];
    int         clr_left[NDUT];
    int         cnt_m   [NDUT];
    res_t       pipe_m  [NDUT][2];
    bit         ev [NDUT];
    bit         ee [NDUT];
    bit         er [NDUT];
    bit         ekn[NDUT];
    logic [7:0] ed [NDUT];

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            for (int a = 0; a < 32; a++) kn_m[k][a] = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic       s_rst, s_w, s_r, oob;
        logic [4:0] s_a;
        logic [7:0] s_d;
        res_t       nr, o;
        s_rst = reset;
        s_w   = write_enb;
        s_r   = read_enb;
        s_a   = address;
        s_d   = data_in;
        for (int k = 0; k < NDUT; k++) begin
            if (!s_rst) begin
                clr_left[k]  = (P_CLR[k] != 0) ? P_DEPTH[k] : 0;
                cnt_m[k]     = 0;
                pipe_m[k][0] = '0;
                pipe_m[k][1] = '0;
                ev[k] = 0; ee[k] = 0; er[k] = 0; ekn[k] = 1; ed[k] = 8'h00;
            end else begin
                nr    = '0;
                nr.kn = 1'b1;
                if (clr_left[k] > 0) begin
                    mem_m[k][cnt_m[k]] = 8'h00;
                    kn_m[k][cnt_m[k]]  = 1'b1;
                    cnt_m[k]++;
                    clr_left[k]--;
                end else if (er[k]) begin
                    oob  = int'(s_a) >= P_DEPTH[k];
                    nr.e = (s_w || s_r) && oob;
                    if (s_r) begin
                        nr.v = 1'b1;
                        if (oob) nr.d = 8'h00;
                        else if (s_w && P_RW[k] == 1) nr.d = s_d;
                        else begin
                            nr.d  = mem_m[k][s_a];
                            nr.kn = kn_m[k][s_a];
                        end
                    end
                    if (s_w && !oob) begin
                        mem_m[k][s_a] = s_d;
                        kn_m[k][s_a]  = 1'b1;
                    end
                end
                o = pipe_m[k][P_LAT[k] - 1];
                pipe_m[k][1] = pipe_m[k][0];
                pipe_m[k][0] = nr;
                ev[k] = o.v;
                ee[k] = o.e;
                if (o.v) begin
                    ed[k]  = o.d;
                    ekn[k] = o.kn;
                end
                er[k] = (clr_left[k] == 0);
            end
        end
        #2;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("model valid[%0d]", k), 32'(vld[k]), 32'(ev[k]));
            chk($sformatf("model err[%0d]", k), 32'(err[k]), 32'(ee[k]));
            chk($sformatf("model ready[%0d]", k), 32'(rdy[k]), 32'(er[k]));
            if (ekn[k]) chk($sformatf("model dout[%0d]", k), 32'(dout[k]), 32'(ed[k]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic w, input logic r, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        write_enb = w;
        read_enb  = r;
        address   = a;
        data_in   = d;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s dout[%0d]", tag, k), 32'(dout[k]), 0);
            chk($sformatf("%s valid[%0d]", tag, k), 32'(vld[k]), 0);
            chk($sformatf("%s ready[%0d]", tag, k), 32'(rdy[k]), 0);
            chk($sformatf("%s err[%0d]", tag, k), 32'(err[k]), 0);
        end
    endtask

    // counts posedges after a release until each DUT raises ready
    task automatic ready_count(input string tag, input int exp0, input int exp1, input int exp2);
        int n0, n1, n2;
        n0 = 0; n1 = 0; n2 = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #2;
            if (rdy[0] && n0 == 0) n0 = n;
            if (rdy[1] && n1 == 0) n1 = n;
            if (rdy[2] && n2 == 0) n2 = n;
        end
        chk({tag, " ready cycles d0"}, n0, exp0);
        chk({tag, " ready cycles d1"}, n1, exp1);
        chk({tag, " ready cycles d2"}, n2, exp2);
    endtask

    // read addr a: d0 result one edge later, d3 two edges later
    task automatic read_lit(input logic [4:0] a, input logic [7:0] e0, input logic [7:0] e3);
        drive(1'b0, 1'b1, a, 8'h00);
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        @(posedge clk);
        #2;
        chk("lit d0 dout", 32'(dout[0]), 32'(e0));
        chk("lit d0 valid", 32'(vld[0]), 1);
        chk("lit d3 valid early", 32'(vld[3]), 0);
        @(posedge clk);
        #2;
        chk("lit d3 dout", 32'(dout[3]), 32'(e3));
        chk("lit d3 valid", 32'(vld[3]), 1);
        chk("lit d0 valid after", 32'(vld[0]), 0);
    endtask

    initial begin
        reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        address = '0; data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // reset in the middle of the sweep
        repeat (10) @(negedge clk);
        chk("d2 ready before midsweep reset", 32'(rdy[2]), 1);
        chk("d0 ready midsweep", 32'(rdy[0]), 0);
        reset = 1'b0;
        #1;
        chk_all_zero("midsweep reset");
        @(negedge clk);
        reset = 1'b1;
        ready_count("sweep", 32, 24, 1);

        read_lit(5'd0,  8'h00, 8'h00);
        read_lit(5'd17, 8'h00, 8'h00);
        read_lit(5'd31, 8'h00, 8'h00);

        // write then read, latency 1 and 2
        drive(1'b1, 1'b0, 5'd5, 8'hA5);
        read_lit(5'd5, 8'hA5, 8'hA5);

        // back-to-back reads, latency 2
        drive(1'b1, 1'b0, 5'd0, 8'h11);
        drive(1'b1, 1'b0, 5'd1, 8'h22);
        drive(1'b1, 1'b0, 5'd2, 8'h33);
        drive(1'b0, 1'b1, 5'd0, 8'h00);
        drive(1'b0, 1'b1, 5'd1, 8'h00);
        drive(1'b0, 1'b1, 5'd2, 8'h00);
        @(posedge clk);
        #2;
        chk("b2b d3 first", 32'(dout[3]), 32'h11);
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        @(posedge clk);
        #2;
        chk("b2b d3 second", 32'(dout[3]), 32'h22);
        chk("b2b d3 second valid", 32'(vld[3]), 1);
        @(posedge clk);
        #2;
        chk("b2b d3 third", 32'(dout[3]), 32'h33);

        // read-during-write at addr 9
        drive(1'b1, 1'b0, 5'd9, 8'h3C);
        drive(1'b1, 1'b1, 5'd9, 8'hC3);
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        @(posedge clk);
        #2;
        chk("rdw d0 read-first", 32'(dout[0]), 32'h3C);
        chk("rdw d2 write-first", 32'(dout[2]), 32'hC3);
        @(posedge clk);
        #2;
        chk("rdw d3 read-first", 32'(dout[3]), 32'h3C);
        chk("rdw d1 write-first", 32'(dout[1]), 32'hC3);
        read_lit(5'd9, 8'hC3, 8'hC3);

        // out-of-range on d1 (DEPTH 24)
        drive(1'b1, 1'b0, 5'd26, 8'h7E);
        drive(1'b0, 1'b1, 5'd26, 8'h00);
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        @(posedge clk);
        #2;
        chk("oob d1 write err", 32'(err[1]), 1);
        chk("oob d1 write no valid", 32'(vld[1]), 0);
        @(posedge clk);
        #2;
        chk("oob d1 read err", 32'(err[1]), 1);
        chk("oob d1 read valid", 32'(vld[1]), 1);
        chk("oob d1 read data", 32'(dout[1]), 0);
        read_lit(5'd26, 8'h7E, 8'h7E);

        // reset with a read in flight
        drive(1'b0, 1'b1, 5'd5, 8'h00);
        @(negedge clk);
        reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        #1;
        chk_all_zero("inflight reset");
        @(negedge clk);
        reset = 1'b1;
        ready_count("resweep", 32, 24, 1);

        // randomized traffic with occasional resets
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                @(negedge clk);
                reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end else begin
                drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
                      5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            end
        end
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        repeat (3) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
Parametrised single-port synchronous RAM. It is the next generation of the 8-bit x 32 testbench RAM. Width, depth and read latency are configurable, and it adds a read-during-write policy. It also adds a post-reset clear sweep, a read-valid flag and out-of-range address detection. It is the DUT for the ram_if-based driver/monitor/scoreboard environment.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
ADDR_WIDTH, 5, width of address
DEPTH, 32, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
RD_LATENCY, 1, cycles from read_enb sample to data_out/data_valid; legal values 1 or 2
RW_MODE, 0, same-address read+write in one cycle: 0 = read-first (old data), 1 = write-first (new data)
CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = no sweep

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset
write_enb  input  1  write strobe, sampled on posedge
read_enb  input  1  read strobe, sampled on posedge
address  input  ADDR_WIDTH  word address for read and write
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  read data, registered
data_valid  output  1  one-cycle pulse aligned with each read result
ready  output  1  1 = accepting commands; 0 during reset/clear sweep
addr_err  output  1  one-cycle pulse aligned with the result of any command whose address >= DEPTH

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - data_out=0, data_valid=0, ready=0, addr_err=0.
  - Read pipeline flushed; FSM goes to CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
  - The memory array itself is not reset.
- FSM states: CLEAR, RUN.
  - CLEAR: a clear counter starts at 0 and writes 0 to word[counter] each posedge. After the write to word DEPTH-1, the FSM goes to RUN, so the sweep takes exactly DEPTH cycles.
  - In CLEAR, ready=0. write_enb/read_enb are ignored: no write, no data_valid, no addr_err.
  - RUN: ready=1 (registered; high on the first posedge after reset release when CLEAR_ON_RESET=0). RUN is left only on reset.
- Write (RUN, write_enb=1, address<DEPTH): word[address] <= data_in at the posedge.
- Read (RUN, read_enb=1):
  - data_out is updated and data_valid=1 exactly RD_LATENCY posedges after the sampling edge.
  - RD_LATENCY=2 adds one output register stage. Back-to-back reads are fully pipelined: one result per cycle.
- No read result in a cycle: data_valid=0 and data_out holds its last value.
- Simultaneous write_enb and read_enb to the same valid address:
  - The write always occurs.
  - The read returns the pre-write word (RW_MODE=0) or data_in (RW_MODE=1).
  - Different addresses: independent, no interaction.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_WIDTH):
  - A write is dropped and memory is unchanged.
  - A read returns data_out=0 with data_valid=1.
  - addr_err pulses for one cycle, aligned with where the read result would appear (RD_LATENCY after sampling) for both read and write.
  - Read+write with the same bad address produces one addr_err pulse.
- Reset asserted mid-sweep or with reads in flight:
  - In-flight results are discarded (no data_valid after reset).
  - The sweep restarts from address 0 on release.
- Data widths are exact; no truncation or extension anywhere except the zero fill.
- Elaboration error if RD_LATENCY is not 1 or 2, or DEPTH is out of range.

Test Plan:
- Clear sweep: DEPTH=32, CLEAR_ON_RESET=1. Release reset, then monitor ready. Required: ready rises exactly 32 cycles after release. Reads of addresses 0, 17 and 31 then return 0x00.
- Write/read, latency 1: write 0xA5 to addr 5, then read addr 5 the next cycle. Required: data_out=0xA5 with data_valid=1 one cycle after the read edge, and data_valid low on all other cycles.
- Latency 2, back-to-back: RD_LATENCY=2. Write 0x11, 0x22, 0x33 to addrs 0-2, then read 0, 1, 2 on consecutive cycles. Required: 0x11, 0x22, 0x33 on three consecutive cycles, the first 2 cycles after the first read edge.
- Read-during-write, RW_MODE=0 vs 1: addr 9 holds 0x3C. Issue write 0xC3 and read addr 9 in the same cycle. Required: RW_MODE=0 returns 0x3C, RW_MODE=1 returns 0xC3, and a later read returns 0xC3 in both.
- Out of range: DEPTH=24, ADDR_WIDTH=5. Write 0x7E to addr 26, then read addr 26. Required: addr_err pulses for each command; the read gives data_out=0x00 with data_valid=1; words 0-23 are unchanged.
- Reset mid-operation: assert reset during the sweep and again with a read in flight. Required: all outputs are 0 immediately with no data_valid afterwards, and the sweep restarts, so ready rises after a further DEPTH cycles.
